programmable_tick_generator: RTL and testbench
==============================================

Name: programmable_tick_generator

Overview:
- Multi-channel, runtime-programmable successor to the fixed-period tick generator.
- Each channel divides the system clock by a programmable divisor. Each channel has three modes: periodic single-cycle pulse, square-wave toggle, and one-shot pulse.
- Feeds VGA sync timing, debounce sampling and display refresh strobes from one block.
- Divisors and modes are loaded over a simple write port, so no resynthesis is needed to retime.

Parameters:
- NUM_CHANNELS, 4, number of independent tick channels (1..16).
- COUNT_WIDTH, 32, width of each divisor register and counter.
- DEFAULT_DIVISOR, 50000, divisor loaded into every channel at reset (must fit COUNT_WIDTH).
- CH_W, $clog2(NUM_CHANNELS) with minimum 1, width of cfg_channel (localparam).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  NUM_CHANNELS  per-channel run enable; low pauses the counter.
- cfg_we  input  1  configuration write strobe, one cycle.
- cfg_channel  input  CH_W  channel addressed by the write.
- cfg_divisor  input  COUNT_WIDTH  new divisor D.
- cfg_mode  input  2  mode select: 00 periodic pulse, 01 toggle, 10 one-shot, 11 treated as 00.
- tick_pulse  output  NUM_CHANNELS  registered one-cycle strobe per event.
- tick_level  output  NUM_CHANNELS  registered square wave; toggle mode only, else held 0.
- busy  output  NUM_CHANNELS  enable[i] & armed[i] (combinational from registered armed).

Behaviour:
- Reset is synchronous and active-high; it takes priority over everything else. On reset:
  - count = 0, divisor = DEFAULT_DIVISOR, mode = 00, armed = 1 for every channel.
  - tick_pulse = 0, tick_level = 0.
- Effective divisor Deff = (divisor == 0) ? 1 : divisor.
- Counting, per channel, on each edge where enable[i] = 1 and armed[i] = 1:
  - If count == Deff-1: count <= 0 and an event occurs.
  - Otherwise: count <= count + 1.
- Latency and period:
  - Starting from count = 0, the event happens on the Deff-th enabled edge.
  - tick_pulse[i] is high for exactly the cycle following that edge.
  - Period is Deff enabled cycles. With Deff = 1, tick_pulse stays high continuously while enabled.
- Per-mode event actions:
  - 00/11: pulse only.
  - 01: pulse, and tick_level[i] toggles on the same edge; square-wave period is 2*Deff.
  - 10: pulse, then armed[i] <= 0. The counter holds at 0 and no further events occur.
- Re-arming in one-shot mode: armed[i] <= 1 on any edge where enable[i] = 0, or on a config write to channel i.
- When enable[i] = 0: the counter and tick_level hold their values, tick_pulse[i] = 0, and no event occurs.
- Config write (cfg_we = 1 and cfg_channel < NUM_CHANNELS), on the same edge:
  - divisor and mode are loaded; count <= 0; tick_level <= 0; armed <= 1.
  - Any event that would have happened on that edge is suppressed, so tick_pulse is 0 the next cycle.
  - Other channels are unaffected.
- A write with cfg_channel >= NUM_CHANNELS is ignored.
- A divisor change takes effect from count = 0. There is no partial-period carry-over.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Counter arithmetic is unsigned COUNT_WIDTH. The compare is against Deff-1, so the counter never wraps past Deff-1. D = 2^COUNT_WIDTH-1 is legal.
- Reset asserted mid-period clears the counter. After reset releases, the first event follows DEFAULT_DIVISOR enabled edges.

Test Plan:
- Reset, then write ch0 D=5 mode 00, enable[0]=1 -> tick_pulse[0] high 1 cycle every 5 cycles. First pulse appears the cycle after the 5th enabled edge.
- ch1 D=3 mode 01, enabled 24 cycles -> tick_level[1] toggles every 3 cycles (period 6). tick_pulse[1] fires 8 times. tick_level[2] stays 0 in mode 00.
- ch2 D=4 mode 10 -> exactly one pulse, then busy[2]=0 and no pulses for 20 cycles. Drop enable for 1 cycle and raise it -> the next pulse comes 4 enabled cycles later.
- ch0 D=0 and separately D=1 -> tick_pulse[0] continuously high while enabled. Deassert enable -> tick_pulse[0]=0 the next cycle and the counter holds.
- ch0 D=10 running, at count=9 write ch0 D=4 -> no pulse the following cycle; the next pulse comes after 4 enabled edges. A write to cfg_channel=5 with NUM_CHANNELS=4 -> no state change.
- Pause ch3 (D=6) at count=2 for 7 cycles, then resume -> a pulse after 4 more enabled edges. Assert reset mid-period -> all outputs 0 the next cycle and divisors return to 50000.

Source files
------------

// File: rtl/programmable_tick_generator.sv
// Multi-channel programmable clock divider.
// Each channel emits a periodic pulse, a square wave or a one-shot pulse at a runtime-loaded divisor.
module programmable_tick_generator #(
  parameter int NUM_CHANNELS = 4,
  parameter int COUNT_WIDTH = 32,
  parameter logic [COUNT_WIDTH-1:0] DEFAULT_DIVISOR = COUNT_WIDTH'(50000),
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_channel,
  input  logic [COUNT_WIDTH-1:0]  cfg_divisor,
  input  logic [1:0]              cfg_mode,
  output logic [NUM_CHANNELS-1:0] tick_pulse,
  output logic [NUM_CHANNELS-1:0] tick_level,
  output logic [NUM_CHANNELS-1:0] busy
);

  typedef enum logic [1:0] {
    MODE_PULSE    = 2'b00,
    MODE_TOGGLE   = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_PULSE_ALT = 2'b11
  } mode_t;

  logic [COUNT_WIDTH-1:0]  count      [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]  divisor    [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]  last_count [NUM_CHANNELS];
  mode_t                   mode       [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] armed;
  logic [NUM_CHANNELS-1:0] pulse_q;
  logic [NUM_CHANNELS-1:0] level_q;
  logic [NUM_CHANNELS-1:0] write_hit;

  // A zero divisor behaves as one, so the terminal count is never below zero.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      last_count[i] = (divisor[i] == '0) ? '0 : divisor[i] - COUNT_WIDTH'(1);
      write_hit[i]  = cfg_we && (cfg_channel == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        count[i]   <= '0;
        divisor[i] <= DEFAULT_DIVISOR;
        mode[i]    <= MODE_PULSE;
      end
      armed   <= '1;
      pulse_q <= '0;
      level_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        pulse_q[i] <= 1'b0;
        // A write restarts the channel and swallows any event due on this edge.
        if (write_hit[i]) begin
          divisor[i] <= cfg_divisor;
          mode[i]    <= mode_t'(cfg_mode);
          count[i]   <= '0;
          level_q[i] <= 1'b0;
          armed[i]   <= 1'b1;
        end else if (!enable[i]) begin
          armed[i] <= 1'b1;
        end else if (armed[i]) begin
          if (count[i] == last_count[i]) begin
            count[i]   <= '0;
            pulse_q[i] <= 1'b1;
            if (mode[i] == MODE_TOGGLE) begin
              level_q[i] <= ~level_q[i];
            end
            if (mode[i] == MODE_ONESHOT) begin
              armed[i] <= 1'b0;
            end
          end else begin
            count[i] <= count[i] + COUNT_WIDTH'(1);
          end
        end
      end
    end
  end

  assign tick_pulse = pulse_q;
  assign tick_level = level_q;
  assign busy       = enable & armed;

endmodule

// File: tb/tb_programmable_tick_generator.sv
// Directed self-checking bench for programmable_tick_generator.
// Five channels are instantiated so that cfg_channel=5 is expressible yet out of range.
module tb_programmable_tick_generator;

  localparam int NCH = 5;
  localparam int CW  = 32;
  localparam int CHW = 3;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] enable;
  logic           cfg_we;
  logic [CHW-1:0] cfg_channel;
  logic [CW-1:0]  cfg_divisor;
  logic [1:0]     cfg_mode;
  logic [NCH-1:0] tick_pulse;
  logic [NCH-1:0] tick_level;
  logic [NCH-1:0] busy;

  int errors = 0;
  int checks = 0;
  int pulseCount;

  programmable_tick_generator #(
    .NUM_CHANNELS(NCH),
    .COUNT_WIDTH(CW),
    .DEFAULT_DIVISOR(CW'(50000))
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .cfg_we(cfg_we),
    .cfg_channel(cfg_channel),
    .cfg_divisor(cfg_divisor),
    .cfg_mode(cfg_mode),
    .tick_pulse(tick_pulse),
    .tick_level(tick_level),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Performs one configuration write on the next edge.
  task automatic applyStimulus(input logic [CHW-1:0] ch, input logic [CW-1:0] d, input logic [1:0] m);
    cfg_we      = 1'b1;
    cfg_channel = ch;
    cfg_divisor = d;
    cfg_mode    = m;
    step(1);
    cfg_we      = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = '0;
    cfg_we      = 1'b0;
    cfg_channel = '0;
    cfg_divisor = '0;
    cfg_mode    = 2'b00;
    step(2);
    checkOutput("reset_pulse", 32'(tick_pulse), 32'h0);
    checkOutput("reset_level", 32'(tick_level), 32'h0);
    checkOutput("reset_busy_disabled", 32'(busy), 32'h0);
    reset = 1'b0;
    enable = 5'b11111;
    #1;
    checkOutput("busy_after_reset", 32'(busy), 32'h1f);

    $display("[TB] periodic pulse, ch0 D=5");
    enable = 5'b00001;
    applyStimulus(3'd0, 32'd5, 2'b00);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      checkOutput($sformatf("ch0_d5_k%0d", k), 32'(tick_pulse[0]), 32'((k % 5) == 0));
    end

    $display("[TB] toggle, ch1 D=3");
    enable = 5'b00010;
    applyStimulus(3'd1, 32'd3, 2'b01);
    pulseCount = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      if (tick_pulse[1]) pulseCount++;
      if (k == 2) checkOutput("ch1_level_k2", 32'(tick_level[1]), 32'h0);
      if (k == 3) checkOutput("ch1_level_k3", 32'(tick_level[1]), 32'h1);
      if (k == 5) checkOutput("ch1_level_k5", 32'(tick_level[1]), 32'h1);
      if (k == 6) checkOutput("ch1_level_k6", 32'(tick_level[1]), 32'h0);
    end
    checkOutput("ch1_pulse_count", 32'(pulseCount), 32'd8);
    checkOutput("ch2_level_mode00", 32'(tick_level[2]), 32'h0);

    $display("[TB] one-shot, ch2 D=4");
    enable = 5'b00100;
    applyStimulus(3'd2, 32'd4, 2'b10);
    step(3);
    checkOutput("ch2_busy_before", 32'(busy[2]), 32'h1);
    checkOutput("ch2_no_pulse_k3", 32'(tick_pulse[2]), 32'h0);
    step(1);
    checkOutput("ch2_pulse_k4", 32'(tick_pulse[2]), 32'h1);
    checkOutput("ch2_busy_after", 32'(busy[2]), 32'h0);
    pulseCount = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (tick_pulse[2]) pulseCount++;
    end
    checkOutput("ch2_no_more_pulses", 32'(pulseCount), 32'd0);
    enable = 5'b00000;
    step(1);
    enable = 5'b00100;
    #1;
    checkOutput("ch2_rearmed_busy", 32'(busy[2]), 32'h1);
    step(3);
    checkOutput("ch2_rearm_k3", 32'(tick_pulse[2]), 32'h0);
    step(1);
    checkOutput("ch2_rearm_k4", 32'(tick_pulse[2]), 32'h1);

    $display("[TB] degenerate divisors on ch0");
    enable = 5'b00001;
    applyStimulus(3'd0, 32'd0, 2'b00);
    checkOutput("ch0_d0_write_edge", 32'(tick_pulse[0]), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      checkOutput($sformatf("ch0_d0_k%0d", k), 32'(tick_pulse[0]), 32'h1);
    end
    enable = 5'b00000;
    step(1);
    checkOutput("ch0_d0_disabled", 32'(tick_pulse[0]), 32'h0);
    enable = 5'b00001;
    applyStimulus(3'd0, 32'd1, 2'b00);
    checkOutput("ch0_d1_write_edge", 32'(tick_pulse[0]), 32'h0);
    step(1);
    checkOutput("ch0_d1_k1", 32'(tick_pulse[0]), 32'h1);
    step(1);
    checkOutput("ch0_d1_k2", 32'(tick_pulse[0]), 32'h1);
    enable = 5'b00000;
    step(1);
    checkOutput("ch0_d1_disabled", 32'(tick_pulse[0]), 32'h0);

    $display("[TB] rewrite mid-period and out-of-range write");
    enable = 5'b00001;
    applyStimulus(3'd0, 32'd10, 2'b00);
    pulseCount = 0;
    for (int k = 0; k < 9; k++) begin
      step(1);
      if (tick_pulse[0]) pulseCount++;
    end
    checkOutput("ch0_d10_no_early_pulse", 32'(pulseCount), 32'd0);
    applyStimulus(3'd0, 32'd4, 2'b00);
    checkOutput("ch0_suppressed_event", 32'(tick_pulse[0]), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) begin
        cfg_we      = 1'b1;
        cfg_channel = 3'd5;
        cfg_divisor = 32'd2;
        cfg_mode    = 2'b01;
      end
      step(1);
      cfg_we = 1'b0;
      checkOutput($sformatf("ch0_d4_k%0d", k), 32'(tick_pulse[0]), 32'((k % 4) == 0));
    end
    checkOutput("bad_channel_level", 32'(tick_level), 32'h0);

    $display("[TB] pause and resume ch3 D=6");
    enable = 5'b01000;
    applyStimulus(3'd3, 32'd6, 2'b00);
    step(2);
    enable = 5'b00000;
    pulseCount = 0;
    for (int k = 0; k < 7; k++) begin
      step(1);
      if (tick_pulse[3]) pulseCount++;
    end
    checkOutput("ch3_paused_no_pulse", 32'(pulseCount), 32'd0);
    enable = 5'b01000;
    step(3);
    checkOutput("ch3_resume_k3", 32'(tick_pulse[3]), 32'h0);
    step(1);
    checkOutput("ch3_resume_k4", 32'(tick_pulse[3]), 32'h1);

    $display("[TB] reset mid-period");
    enable = 5'b01010;
    step(3);
    checkOutput("ch1_level_before_reset", 32'(tick_level[1]), 32'h1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checkOutput("reset_mid_pulse", 32'(tick_pulse), 32'h0);
    checkOutput("reset_mid_level", 32'(tick_level), 32'h0);
    pulseCount = 0;
    for (int k = 0; k < 49999; k++) begin
      step(1);
      if (tick_pulse != '0) pulseCount++;
    end
    checkOutput("default_divisor_no_early", 32'(pulseCount), 32'd0);
    step(1);
    checkOutput("default_divisor_event", 32'(tick_pulse), 32'h0a);
    checkOutput("default_mode_level", 32'(tick_level), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
